// File: rtl/logic_sched_pkg.sv
// Shared definitions for logic_op_scheduler: output-stage state encoding and default widths.
package logic_sched_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam int DEF_W     = 8;
  localparam int DEF_N_REQ = 4;
  localparam int DEF_ID_W  = 2;

endpackage

// File: rtl/gate_unit.sv
// Purely combinational bitwise logic unit: x = a|b, y = a^b^c, z = b&~c.
module gate_unit
  import logic_sched_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_c,
  output logic [W-1:0] o_x,
  output logic [W-1:0] o_y,
  output logic [W-1:0] o_z
);

  assign o_x = i_a | i_b;
  assign o_y = i_a ^ i_b ^ i_c;
  assign o_z = i_b & ~i_c;

endmodule

// File: rtl/logic_op_scheduler.sv
// Arbitrates N requesters onto one shared gate_unit with a single registered result stage.
// Define ROUND_ROBIN_EN for rotating priority; otherwise lowest index wins.
module logic_op_scheduler
  import logic_sched_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int ID_W  = DEF_ID_W,
  parameter int W     = DEF_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] a_in,
  input  logic [N_REQ*W-1:0] b_in,
  input  logic [N_REQ*W-1:0] c_in,
  output logic [N_REQ-1:0]   gnt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       x,
  output logic [W-1:0]       y,
  output logic [W-1:0]       z,
  output logic [ID_W-1:0]    out_id
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              w_load;
  logic              w_can_issue;
  logic              w_issue;
  logic              w_found;
  logic              w_hit;
  logic [ID_W-1:0]   w_win;
  logic [ID_W-1:0]   w_ptr;
  logic [ID_W:0]     w_cand;
  logic [N_REQ-1:0]  w_req_sh;
  logic [W-1:0]      w_a;
  logic [W-1:0]      w_b;
  logic [W-1:0]      w_c;
  logic [W-1:0]      w_x;
  logic [W-1:0]      w_y;
  logic [W-1:0]      w_z;
  logic [W-1:0]      r_x;
  logic [W-1:0]      r_y;
  logic [W-1:0]      r_z;
  logic [ID_W-1:0]   r_id;

`ifdef ROUND_ROBIN_EN
  logic [ID_W-1:0]   r_ptr;

  // Rotate priority to just past the latest winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_issue) begin
      r_ptr <= (w_win == ID_W'(N_REQ - 1)) ? '0 : w_win + ID_W'(1);
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = '0;
`endif

  assign w_can_issue = (r_state == ST_EMPTY) | out_ready;
  assign w_issue     = w_can_issue & w_found;

  // Scan requests from the priority pointer upward, modulo N_REQ.
  always_comb begin
    w_found  = 1'b0;
    w_win    = '0;
    w_cand   = '0;
    w_req_sh = '0;
    w_hit    = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      w_cand   = {1'b0, w_ptr} + (ID_W+1)'(i);
      w_cand   = (w_cand >= (ID_W+1)'(N_REQ)) ? w_cand - (ID_W+1)'(N_REQ) : w_cand;
      w_req_sh = req >> w_cand;
      w_hit    = ~w_found & w_req_sh[0];
      w_win    = w_hit ? w_cand[ID_W-1:0] : w_win;
      w_found  = w_found | w_hit;
    end
  end

  // One-hot grant; suppressed during reset and under backpressure.
  always_comb begin
    gnt = '0;
    if (w_issue && !rst) begin
      gnt = {{(N_REQ-1){1'b0}}, 1'b1} << w_win;
    end else begin
      gnt = '0;
    end
  end

  assign w_a = W'(a_in >> (int'(w_win) * W));
  assign w_b = W'(b_in >> (int'(w_win) * W));
  assign w_c = W'(c_in >> (int'(w_win) * W));

  gate_unit #(.W(W)) u_gate (
    .i_a (w_a),
    .i_b (w_b),
    .i_c (w_c),
    .o_x (w_x),
    .o_y (w_y),
    .o_z (w_z)
  );

  // Output-stage next state and load decision.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_issue) begin
          w_state_nxt = ST_FULL;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_ready && w_issue) begin
          w_state_nxt = ST_FULL;
          w_load      = 1'b1;
        end else if (out_ready) begin
          w_state_nxt = ST_EMPTY;
        end else begin
          w_state_nxt = ST_FULL;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Result register keeps its last value when drained without refill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x  <= '0;
      r_y  <= '0;
      r_z  <= '0;
      r_id <= '0;
    end else if (w_load) begin
      r_x  <= w_x;
      r_y  <= w_y;
      r_z  <= w_z;
      r_id <= w_win;
    end
  end

  assign out_valid = (r_state == ST_FULL);
  assign x         = r_x;
  assign y         = r_y;
  assign z         = r_z;
  assign out_id    = r_id;

endmodule

// File: tb/tb_logic_op_scheduler.sv
// Table-driven bench for logic_op_scheduler with a result scoreboard; follows ROUND_ROBIN_EN.
module tb_logic_op_scheduler;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;
`ifdef ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic [W-1:0]  z;
    logic [IW-1:0] id;
  } res_t;

  typedef struct {
    logic [N-1:0]   req;
    logic           rdy;
    logic [N-1:0]   gnt_rr;
    logic [N-1:0]   gnt_fp;
    logic [N*W-1:0] a;
    logic [N*W-1:0] b;
    logic [N*W-1:0] c;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_in, b_in, c_in;
  logic [N-1:0]   gnt;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   x, y, z;
  logic [IW-1:0]  out_id;

  res_t sb[$];
  res_t last;
  logic m_valid;
  int   n_vec  = 0;
  int   n_fail = 0;
  vec_t tbl[15];

  logic_op_scheduler #(.N_REQ(N), .ID_W(IW), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .c_in      (c_in),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x         (x),
    .y         (y),
    .z         (z),
    .out_id    (out_id)
  );

  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, expected finish before 20000");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [N*W-1:0] put(input int k, input logic [W-1:0] v);
    logic [N*W-1:0] t;
    t = N*W'($urandom);
    t[k*W +: W] = v;
    return t;
  endfunction

  function automatic vec_t mk(input logic [N-1:0] r, input logic rdy,
                              input logic [N-1:0] grr, input logic [N-1:0] gfp);
    vec_t v;
    v.req = r; v.rdy = rdy; v.gnt_rr = grr; v.gnt_fp = gfp;
    v.a = N*W'($urandom); v.b = N*W'($urandom); v.c = N*W'($urandom);
    return v;
  endfunction

  task automatic check_out(input string name);
    check({name, " x"}, 32'(x), 32'(last.x));
    check({name, " y"}, 32'(y), 32'(last.y));
    check({name, " z"}, 32'(z), 32'(last.z));
    check({name, " out_id"}, 32'(out_id), 32'(last.id));
  endtask

  // Drive one cycle at posedge+1, check gnt, then check the registered stage after the edge.
  task automatic apply(input string name, input logic [N-1:0] r,
                       input logic [N*W-1:0] a, input logic [N*W-1:0] b, input logic [N*W-1:0] c,
                       input logic rdy, input logic [N-1:0] eg);
    res_t e;
    int   k;
    logic iss;
    req = r; a_in = a; b_in = b; c_in = c; out_ready = rdy;
    #1;
    check({name, " gnt"}, 32'(gnt), 32'(eg));
    iss = |eg;
    k = 0;
    for (int i = 0; i < N; i++) if (eg[i]) k = i;
    if (iss) begin
      e.x  = a[k*W +: W] | b[k*W +: W];
      e.y  = a[k*W +: W] ^ b[k*W +: W] ^ c[k*W +: W];
      e.z  = b[k*W +: W] & ~c[k*W +: W];
      e.id = IW'(k);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (iss) m_valid = 1'b1;
    else if (rdy) m_valid = 1'b0;
    check({name, " out_valid"}, 32'(out_valid), 32'(m_valid));
    if (iss) begin
      if (sb.size() == 0) begin
        check({name, " scoreboard"}, 32'(0), 32'(1));
      end else begin
        last = sb.pop_front();
      end
    end
    check_out(name);
  endtask

  task automatic reset_check(input string name);
    check({name, " gnt"}, 32'(gnt), 32'(0));
    check({name, " out_valid"}, 32'(out_valid), 32'(0));
    check({name, " x"}, 32'(x), 32'(0));
    check({name, " y"}, 32'(y), 32'(0));
    check({name, " z"}, 32'(z), 32'(0));
    check({name, " out_id"}, 32'(out_id), 32'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 4'b1111; out_ready = 1'b1;
    #1;
    reset_check("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_valid = 1'b0;
    last = '{x: 8'd0, y: 8'd0, z: 8'd0, id: 2'd0};
    sb.delete();
  endtask

  initial begin
    rst = 1'b1; req = '0; a_in = '0; b_in = '0; c_in = '0; out_ready = 1'b0;
    #1;
    do_reset();

    apply("single", 4'b0001, put(0, 8'd21), put(0, 8'd53), put(0, 8'd36), 1'b1, 4'b0001);
    check("single x const", 32'(x), 32'd53);
    check("single y const", 32'(y), 32'd4);
    check("single z const", 32'(z), 32'd17);

    apply("bp_load", 4'b0001, put(0, 8'd137), put(0, 8'd94), put(0, 8'd129), 1'b1, 4'b0001);
    check("bp_load x const", 32'(x), 32'd223);
    check("bp_load y const", 32'(y), 32'd86);
    check("bp_load z const", 32'(z), 32'd94);
    for (int i = 0; i < 3; i++)
      apply("bp_stall", 4'b0010, put(1, 8'd7), put(1, 8'd9), put(1, 8'd3), 1'b0, 4'b0000);
    apply("bp_release", 4'b0010, put(1, 8'd7), put(1, 8'd9), put(1, 8'd3), 1'b1, 4'b0010);
    apply("reload", 4'b0001, put(0, 8'd137), put(0, 8'd94), put(0, 8'd129), 1'b1, 4'b0001);
    apply("drain", 4'b0000, put(0, 8'd0), put(0, 8'd0), put(0, 8'd0), 1'b1, 4'b0000);
    check("drain x kept", 32'(x), 32'd223);
    check("drain y kept", 32'(y), 32'd86);
    check("drain z kept", 32'(z), 32'd94);

    do_reset();
    tbl[0]  = mk(4'b0001, 1'b1, 4'b0001, 4'b0001);
    tbl[1]  = mk(4'b1111, 1'b1, 4'b0010, 4'b0001);
    tbl[2]  = mk(4'b1111, 1'b1, 4'b0100, 4'b0001);
    tbl[3]  = mk(4'b1111, 1'b1, 4'b1000, 4'b0001);
    tbl[4]  = mk(4'b1111, 1'b1, 4'b0001, 4'b0001);
    tbl[5]  = mk(4'b1010, 1'b0, 4'b0000, 4'b0000);
    tbl[6]  = mk(4'b1010, 1'b0, 4'b0000, 4'b0000);
    tbl[7]  = mk(4'b1010, 1'b1, 4'b0010, 4'b0010);
    tbl[8]  = mk(4'b0000, 1'b1, 4'b0000, 4'b0000);
    tbl[9]  = mk(4'b1001, 1'b0, 4'b1000, 4'b0001);
    tbl[10] = mk(4'b1001, 1'b1, 4'b0001, 4'b0001);
    tbl[11] = mk(4'b0000, 1'b0, 4'b0000, 4'b0000);
    tbl[12] = mk(4'b0000, 1'b1, 4'b0000, 4'b0000);
    tbl[13] = mk(4'b0100, 1'b0, 4'b0100, 4'b0100);
    tbl[14] = mk(4'b0000, 1'b1, 4'b0000, 4'b0000);
    for (int i = 0; i < 15; i++)
      apply($sformatf("tbl%0d", i), tbl[i].req, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].rdy,
            RR ? tbl[i].gnt_rr : tbl[i].gnt_fp);

    apply("midop_load", 4'b0010, put(1, 8'd200), put(1, 8'd15), put(1, 8'd60), 1'b1, 4'b0010);
    req = 4'b0000; out_ready = 1'b0;
    #2;
    rst = 1'b1; req = 4'b1111; out_ready = 1'b1;
    #1;
    reset_check("midop_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_valid = 1'b0;
    last = '{x: 8'd0, y: 8'd0, z: 8'd0, id: 2'd0};
    apply("post_rst", 4'b1100, N*W'($urandom), N*W'($urandom), N*W'($urandom), 1'b1, 4'b0100);

    apply("prio0", 4'b1001, N*W'($urandom), N*W'($urandom), N*W'($urandom), 1'b1, RR ? 4'b1000 : 4'b0001);
    apply("prio1", 4'b1001, N*W'($urandom), N*W'($urandom), N*W'($urandom), 1'b1, 4'b0001);
    apply("prio2", 4'b1001, N*W'($urandom), N*W'($urandom), N*W'($urandom), 1'b1, RR ? 4'b1000 : 4'b0001);
    apply("prio3", 4'b1001, N*W'($urandom), N*W'($urandom), N*W'($urandom), 1'b1, 4'b0001);
    apply("final_drain", 4'b0000, '0, '0, '0, 1'b1, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_op_scheduler.md
# logic_op_scheduler

Shares one 8-bit three-output logic unit (x = a|b, y = a^b^c, z = b&~c) among N requesters. Arbitrates pending requests, issues one operand set per cycle into a single registered result stage, and presents results with the winning requester's ID on a valid/ready output port. Sits between the operand-producing blocks and the result consumer in the procedural-logic datapath.

## Interface
Parameters:
- N_REQ, 4: number of requesters (2..8)
- ID_W, 2: width of requester ID; must satisfy 2^ID_W >= N_REQ
- W, 8: operand/result width

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  N_REQ  per-requester request; held high until granted
- a_in  in  N_REQ*W  operand a, requester i at bits [i*W +: W]
- b_in  in  N_REQ*W  operand b, same packing
- c_in  in  N_REQ*W  operand c, same packing
- gnt  out  N_REQ  one-hot, combinational; high in the cycle the requester's operands are captured
- out_valid  out  1  result register holds an undelivered result
- out_ready  in  1  consumer accepts the result when out_valid & out_ready
- x  out  W  registered a|b
- y  out  W  registered a^b^c
- z  out  W  registered b&~c
- out_id  out  ID_W  index of the requester that produced the current result

## Operation
- Output-stage FSM, 2 states: EMPTY (out_valid=0), FULL (out_valid=1).
- can_issue = EMPTY | (FULL & out_ready).
- When can_issue & |req: arbiter selects winner k, drives gnt[k]=1, and on the edge loads x/y/z from the logic unit on requester k's operands, out_id=k, state to FULL.
- When FULL & out_ready & no req: state goes to EMPTY; x/y/z/out_id keep their last values.
- When FULL & !out_ready: hold all outputs; gnt=0 regardless of req (backpressure).
- Simultaneous drain and issue (FULL & out_ready & |req): old result leaves, new result loads on the same edge, out_valid stays 1.
- Requester protocol: operands must be stable while req=1; the requester deasserts req or presents the next operands on the cycle after gnt.
- Arbitration: priority pointer ptr (ID_W bits). Scan from ptr upward, mod N_REQ; the first set req wins. After a grant to k, ptr = (k+1) mod N_REQ; wrap from N_REQ-1 to 0. ptr does not change when there is no grant.
- Logic results are bitwise at W bits with no carries; no width extension.
- Reset (asynchronous, any time including mid-transfer): state EMPTY, out_valid=0, x=y=z=0, out_id=0, ptr=0. gnt=0 while rst=1. An in-flight result is discarded.

## Timing
- Latency: gnt in cycle n, result valid in cycle n+1.
- Throughput: 1 result per cycle while out_ready=1 and any req is pending.
- gnt depends combinationally on req, state, out_ready and ptr. There is no combinational path from a_in/b_in/c_in to any output.
- out_valid, x, y, z and out_id come straight from registers.

## Configuration
- ROUND_ROBIN_EN defined: rotating priority as above. Starvation-free; any requester waits at most N_REQ-1 grants.
- ROUND_ROBIN_EN undefined: fixed priority, lowest index wins. ptr logic is removed and treated as 0. Continuous req0 starves all others.

## Structure
- Shared package logic_sched_pkg holds:
  - FSM state encoding: ST_EMPTY=1'b0, ST_FULL=1'b1
  - default widths (W=8, N_REQ=4, ID_W=2)
- One sub-module, gate_unit: purely combinational W-bit x/y/z logic, instantiated once after the operand mux.
- Arbiter and pointer stay inline in logic_op_scheduler.

## Test plan
- Single request: req=0001, a=21 b=53 c=36, out_ready=1 -> gnt=0001 in cycle n; in cycle n+1 out_valid=1, x=53 y=4 z=17, out_id=0.
- Round-robin fairness (ROUND_ROBIN_EN): all four req held high, out_ready=1 -> gnt sequence 0001, 0010, 0100, 1000, 0001; out_id sequence 0,1,2,3,0; one result per cycle.
- Backpressure: out_valid=1 with a=137 b=94 c=129 result (x=223 y=86 z=94), out_ready=0 for 3 cycles with req=0010 -> gnt=0 and outputs stable; out_ready=1 -> gnt=0010 the same cycle and the new result loads on the next edge.
- Drain without refill: FULL, out_ready=1, req=0 -> out_valid=0 next cycle; x/y/z retain 223/86/94.
- Fixed priority (ROUND_ROBIN_EN undefined): req=1001 held -> gnt=0001 every cycle; requester 3 is never granted.
- Reset mid-operation: assert rst asynchronously while FULL with ptr=2 -> out_valid=0, x=y=z=0, out_id=0 immediately. After release, req=1100 -> gnt=0100 (ptr=0 scan reaches index 2 first).
